// File: rtl/direction_pkg.sv
// Shared types for the entry/exit direction detector: FSM state encoding and
// the {a,b} debounced sensor pair codes.
package direction_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInA,
    StInAb,
    StInB,
    StOutB,
    StOutBa,
    StOutA,
    StWaitClr
  } state_e;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_A    = 2'b10;
  localparam logic [1:0] P_B    = 2'b01;
  localparam logic [1:0] P_AB   = 2'b11;

  // Pair level a state implies; WAIT_CLR has no fixed level and reports P_NONE.
  function automatic logic [1:0] state_pair(state_e s);
    logic [1:0] p;
    p = P_NONE;
    case (s)
      StInA, StOutA:   p = P_A;
      StInAb, StOutBa: p = P_AB;
      StInB, StOutB:   p = P_B;
      default:         p = P_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a hold-count debounce filter for one
// asynchronous presence sensor.
module debounce_filter #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  output logic dout_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

  logic            sync1_q, sync2_q;
  logic            dout_q, dout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level matches the output wipes the count.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (sync2_q != dout_q) begin
      if (cnt_q == CntW'(DEBOUNCE - 1)) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/direction_detector.sv
// Turns outer (A) / inner (B) presence sensors into one-cycle entry (sum),
// exit (res) and illegal-transition (err) pulses for the occupancy counter.
module direction_detector
  import direction_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sensor_a_i,
  input  logic sensor_b_i,
  output logic sum_o,
  output logic res_o,
  output logic err_o
);

  logic       dbn_a, dbn_b;
  logic [1:0] pair;
  logic       pulse_q;
  logic       illegal;
  state_e     state_q;
  logic       sum_q, res_q, err_q;

  debounce_filter #(
    .DEBOUNCE(DEBOUNCE)
  ) u_filter_a (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .din_i  (sensor_a_i),
    .dout_o (dbn_a)
  );

  debounce_filter #(
    .DEBOUNCE(DEBOUNCE)
  ) u_filter_b (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .din_i  (sensor_b_i),
    .dout_o (dbn_b)
  );

  assign pair    = {dbn_a, dbn_b};
  assign pulse_q = sum_q | res_q | err_q;
  // Both bits flipped relative to the level the current state implies.
  assign illegal = (state_q != StWaitClr) && (pair == ~state_pair(state_q));

  // A pulse directly after another is dropped so outputs never stay high two
  // cycles; only reachable with very short DEBOUNCE settings.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sum_q   <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sum_q <= 1'b0;
      res_q <= 1'b0;
      err_q <= 1'b0;
      if (illegal) begin
        err_q   <= ~pulse_q;
        state_q <= (pair == P_NONE) ? StIdle : StWaitClr;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pair == P_A) state_q <= StInA;
            else if (pair == P_B) state_q <= StOutB;
          end
          StInA: begin
            if (pair == P_AB) state_q <= StInAb;
            else if (pair == P_NONE) state_q <= StIdle;
          end
          StInAb: begin
            if (pair == P_B) state_q <= StInB;
            else if (pair == P_A) state_q <= StInA;
          end
          StInB: begin
            if (pair == P_NONE) begin
              state_q <= StIdle;
              sum_q   <= ~pulse_q;
            end else if (pair == P_AB) begin
              state_q <= StInAb;
            end
          end
          StOutB: begin
            if (pair == P_AB) state_q <= StOutBa;
            else if (pair == P_NONE) state_q <= StIdle;
          end
          StOutBa: begin
            if (pair == P_A) state_q <= StOutA;
            else if (pair == P_B) state_q <= StOutB;
          end
          StOutA: begin
            if (pair == P_NONE) begin
              state_q <= StIdle;
              res_q   <= ~pulse_q;
            end else if (pair == P_AB) begin
              state_q <= StOutBa;
            end
          end
          StWaitClr: begin
            if (pair == P_NONE) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sum_o = sum_q;
  assign res_o = res_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_direction_detector.sv
// Scoreboard bench for direction_detector: tasks push expected pulses with
// their cycle stamp, a negedge monitor pops and compares every DUT pulse.
module tb_direction_detector;
  import direction_pkg::*;

  localparam int unsigned Debounce = 4;
  localparam int          Lat      = Debounce + 3;
  localparam int          Hold     = 20;
  localparam int          MinStep  = Debounce + 1;

  typedef enum logic [1:0] {EvSum, EvRes, EvErr} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, sensor_a, sensor_b;
  logic sum, res, err;

  exp_t sb_q[$];
  exp_t head;
  ev_e  obs_kind;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_sum  = 0;
  int   n_res  = 0;
  int   n_err  = 0;
  logic prev_any = 1'b0;

  direction_detector #(
    .DEBOUNCE(Debounce)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .sensor_a_i(sensor_a),
    .sensor_b_i(sensor_b),
    .sum_o     (sum),
    .res_o     (res),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sum | res | err) begin
      obs_kind = sum ? EvSum : (res ? EvRes : EvErr);
      if (sum) n_sum++;
      if (res) n_res++;
      if (err) n_err++;
      checks++;
      if ($countones({sum, res, err}) != 1 || prev_any) begin
        errors++;
        $display("FAIL pulse_shape cyc=%0d got sum/res/err=%b%b%b prev=%b, need one-hot and isolated",
                 cyc, sum, res, err, prev_any);
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got %s, need none", cyc, obs_kind.name());
      end else begin
        head = sb_q.pop_front();
        if (obs_kind !== head.kind || cyc != head.cyc) begin
          errors++;
          $display("FAIL scoreboard got %s@%0d, need %s@%0d",
                   obs_kind.name(), cyc, head.kind.name(), head.cyc);
        end
      end
    end
    prev_any = sum | res | err;
  end

  task automatic step(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input ev_e k);
    exp_t e;
    e.kind = k;
    e.cyc  = cyc + Lat;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sum !== 1'b0) begin errors++; $display("FAIL reset_sum got %b need 0", sum); end
    checks++;
    if (res !== 1'b0) begin errors++; $display("FAIL reset_res got %b need 0", res); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b need 0", err); end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL reset_state got %0d need %0d", dut.state_q, StIdle);
    end
    reset = 1'b0;
    step(1'b0, 1'b0, Hold);
  endtask

  task automatic test_entry();
    int s0, r0, e0;
    s0 = n_sum; r0 = n_res; e0 = n_err;
    step(1'b1, 1'b0, Hold);
    step(1'b1, 1'b1, Hold);
    step(1'b0, 1'b1, Hold);
    expect_ev(EvSum);
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_sum - s0 != 1 || n_res != r0 || n_err != e0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL entry got sum=%0d res=%0d err=%0d pending=%0d, need 1/0/0/0",
               n_sum - s0, n_res - r0, n_err - e0, sb_q.size());
    end
  endtask

  task automatic test_exit_abort();
    int s0, r0;
    s0 = n_sum; r0 = n_res;
    step(1'b0, 1'b1, Hold);
    step(1'b1, 1'b1, Hold);
    step(1'b1, 1'b0, Hold);
    expect_ev(EvRes);
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_res - r0 != 1 || n_sum != s0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL exit got res=%0d sum=%0d pending=%0d, need 1/0/0",
               n_res - r0, n_sum - s0, sb_q.size());
    end
    r0 = n_res;
    step(1'b1, 1'b0, Hold);
    step(1'b1, 1'b1, Hold);
    step(1'b1, 1'b0, Hold);
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_res != r0 || n_sum != s0) begin
      errors++;
      $display("FAIL abort got sum=%0d res=%0d, need 0/0", n_sum - s0, n_res - r0);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    sensor_a = 1'b1;
    for (int i = 0; i < 3 + Hold; i++) begin
      if (i == 3) sensor_a = 1'b0;
      @(posedge clk);
      #1;
      if (dut.u_filter_a.dout_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch3 got rise=%b need 0", seen); end
    seen = 1'b0;
    sensor_a = 1'b1;
    for (int i = 0; i < 4 + Hold; i++) begin
      if (i == 4) sensor_a = 1'b0;
      @(posedge clk);
      #1;
      if (dut.u_filter_a.dout_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || dut.u_filter_a.dout_o !== 1'b0 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL glitch4 got rise=%b final=%b state=%0d, need 1/0/%0d",
               seen, dut.u_filter_a.dout_o, dut.state_q, StIdle);
    end
  endtask

  task automatic test_illegal();
    int s0, r0, e0;
    s0 = n_sum; r0 = n_res; e0 = n_err;
    expect_ev(EvErr);
    step(1'b1, 1'b1, Hold);
    step(1'b0, 1'b1, Hold);
    step(1'b1, 1'b1, Hold);
    step(1'b0, 1'b1, Hold);
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_err - e0 != 1 || n_sum != s0 || n_res != r0 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL illegal got err=%0d sum=%0d res=%0d state=%0d, need 1/0/0/%0d",
               n_err - e0, n_sum - s0, n_res - r0, dut.state_q, StIdle);
    end
    step(1'b1, 1'b0, Hold);
    step(1'b1, 1'b1, Hold);
    step(1'b0, 1'b1, Hold);
    expect_ev(EvSum);
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_sum - s0 != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_recover got sum=%0d pending=%0d, need 1/0", n_sum - s0, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s0, e0;
    s0 = n_sum; e0 = n_err;
    step(1'b1, 1'b0, Hold);
    step(1'b1, 1'b1, Hold);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Sensors stay blocked through reset, so the filters see 00->11 afterwards.
    expect_ev(EvErr);
    reset = 1'b0;
    checks++;
    if ({sum, res, err} !== 3'b000 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL reset_mid got outs=%b state=%0d, need 000/%0d",
               {sum, res, err}, dut.state_q, StIdle);
    end
    step(1'b1, 1'b1, Hold);
    step(1'b0, 1'b1, Hold);
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_sum != s0 || n_err - e0 != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_after got sum=%0d err=%0d pending=%0d, need 0/1/0",
               n_sum - s0, n_err - e0, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int s0, r0;
    s0 = n_sum; r0 = n_res;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, MinStep);
      step(1'b1, 1'b1, MinStep);
      step(1'b0, 1'b1, MinStep);
      expect_ev(EvSum);
      step(1'b0, 1'b0, MinStep);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, MinStep);
      step(1'b1, 1'b1, MinStep);
      step(1'b1, 1'b0, MinStep);
      expect_ev(EvRes);
      step(1'b0, 1'b0, MinStep);
    end
    step(1'b0, 1'b0, Hold);
    checks++;
    if (n_sum - s0 != 10 || n_res - r0 != 3 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back got sum=%0d res=%0d pending=%0d, need 10/3/0",
               n_sum - s0, n_res - r0, sb_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout, need completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    test_reset();
    test_entry();
    test_exit_abort();
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/direction_detector.md
# direction_detector

Converts two raw presence sensors (A outer, B inner) into the single-cycle `sum` / `res` commands consumed by the saturating up/down occupancy counter. Each sensor is synchronized and debounced. A sequence FSM then recognises a complete entry (A→B) or exit (B→A) crossing. Exactly one `sum` pulse is emitted per entry and one `res` pulse per exit; aborted crossings produce nothing, and illegal jumps produce `err`.

## Interface

- `DEBOUNCE`, 4: consecutive synchronized cycles an input must hold its new level before the debounced level changes (≥1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `sensor_a`  in  1  raw outer sensor, asynchronous, 1 = beam blocked.
- `sensor_b`  in  1  raw inner sensor, asynchronous, 1 = beam blocked.
- `sum`  out  1  registered one-cycle pulse: entry completed.
- `res`  out  1  registered one-cycle pulse: exit completed.
- `err`  out  1  registered one-cycle pulse: illegal sensor transition detected.

## Operation

- **Per-sensor path:**
  - 2-flop synchronizer, then debounce filter.
  - The filter counter increments while the synchronized value ≠ debounced value and clears on any cycle they are equal.
  - The debounced value takes the new level on the edge where the counter reaches `DEBOUNCE`; the counter clears at that edge.
- **Pair `{a,b}`:** the debounced values, evaluated once per cycle by the FSM.
- **States:** IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR.
- **Entry path:**
  - IDLE --10--> IN_A --11--> IN_AB --01--> IN_B --00--> IDLE, asserting `sum`.
- **Exit path:**
  - IDLE --01--> OUT_B --11--> OUT_BA --10--> OUT_A --00--> IDLE, asserting `res`.
- **Backtrack (no pulse, no err):**
  - IN_A --00--> IDLE; IN_AB --10--> IN_A; IN_B --11--> IN_AB.
  - Symmetric on the exit path: OUT_B --00--> IDLE; OUT_BA --01--> OUT_B; OUT_A --11--> OUT_BA.
- **Illegal transition:** any change of both bits in the same cycle (00↔11, 10↔01).
  - Assert `err` and go to WAIT_CLR.
  - If the new pair is 00, go directly to IDLE instead.
- **WAIT_CLR:** stays until pair = 00, then IDLE. No pulses are generated in WAIT_CLR.
- Pair unchanged → state unchanged.
- `sum`, `res` and `err` are mutually exclusive, never high two consecutive cycles, and default to 0.
- **Reset:**
  - State IDLE.
  - Synchronizer flops, debounced values and filter counters all 0.
  - `sum = res = err = 0`.
  - Reset mid-crossing discards the crossing with no pulse.
  - If both sensors are already blocked when reset releases, the first debounced update is 00→11, which gives `err` and then WAIT_CLR.

## Timing

- Raw level change held stable → debounced change: 2 (sync) + `DEBOUNCE` cycles after the first sampling edge.
- Debounced pair change → FSM state and output pulse: registered on the next edge.
- Total raw-to-pulse latency: `DEBOUNCE` + 3 cycles. With `DEBOUNCE` = 4, this is 7 cycles.
- Glitches shorter than `DEBOUNCE` synchronized cycles are fully rejected.
- Counter width: $clog2(`DEBOUNCE`+1).
- Filter behaviour when the raw input returns to the debounced level before the count completes: the counter clears, with no partial credit.
- Minimum spacing between two legal crossings: 4·(`DEBOUNCE`+1) cycles, which the FSM sustains back-to-back.

## Structure

- **Shared package `direction_pkg`:**
  - State enum (8 states, 3 bits).
  - Pair encoding constants P_NONE = 2'b00, P_A = 2'b10, P_B = 2'b01, P_AB = 2'b11.
- **Sub-module `debounce_filter`:**
  - Parameter `DEBOUNCE`; ports `clk`, `reset`, `din`, `dout`.
  - Contains the synchronizer and the counter; instantiated twice.
- **Top level:** FSM, output registers and pair concatenation.

## Test plan

All scenarios use `DEBOUNCE` = 4.

- **Entry:** `sensor_a`/`sensor_b` stepped 00→10→11→01→00, 20 cycles per step → exactly one `sum` pulse, 7 cycles after the final raw edge; `res` = `err` = 0 throughout.
- **Exit:** 00→01→11→10→00 → exactly one `res` pulse. **Abort:** 00→10→11→10→00 → no pulse.
- **Glitch rejection:** 3-cycle high spike on `sensor_a` → debounced value never changes, no output. A 4-cycle spike → the debounced value rises, then returns to 0 → IN_A→IDLE with no pulse.
- **Illegal jump:** both raw inputs rise on the same edge → one `err` pulse; with sensors then held 01 and 11 → no `sum`/`res` until pair = 00; then a clean entry → `sum`.
- **Reset mid-crossing:** reset asserted in IN_AB for 1 cycle → all outputs 0 and state IDLE on the next edge; continuing 01→00 yields no `sum`. Reset with both sensors held high → `err` after 7 cycles.
- **Back-to-back:** 10 consecutive entries at minimum spacing followed by 3 exits → exactly 10 `sum` and 3 `res` pulses, none overlapping.
